input_req_buffer: RTL and testbench
===================================

INPUT_REQ_BUFFER -- requirements
Module: input_req_buffer

Interface
REQ-001 SHALL have parameter NR, default 5, number of output ports (width of REQ/GRT).
REQ-002 SHALL have parameter FW, default 16, flit width in bits.
REQ-003 SHALL have parameter DEPTH, default 4, FIFO depth in flits, power of two.
REQ-004 SHALL have port CLK  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port IN_FLIT  input  FW  incoming flit.
REQ-007 SHALL have port IN_VALID  input  1  IN_FLIT valid.
REQ-008 SHALL have port IN_READY  output  1  buffer can accept a flit this cycle.
REQ-009 SHALL have port REQ  output  NR  one-hot request to the round-robin arbiter.
REQ-010 SHALL have port GRT  input  NR  one-hot grant from the round-robin arbiter.
REQ-011 SHALL have port OUT_FLIT  output  FW  flit forwarded to the crossbar.
REQ-012 SHALL have port OUT_VALID  output  1  OUT_FLIT valid, single-cycle pulse per flit.
REQ-013 SHALL have port ERR  output  1  single-cycle pulse on a dropped flit.

Function
REQ-014 SHALL decode flit type from IN_FLIT[FW-1:FW-2]: 01 HEAD, 00 BODY, 10 TAIL, 11 SINGLE (head and tail).
REQ-015 SHALL decode destination port from HEAD/SINGLE bits [FW-3:FW-5], unsigned.
REQ-016 SHALL push IN_FLIT when IN_VALID && IN_READY; IN_READY = !full, from registered count only, so a push into a full FIFO is refused even when a pop occurs in the same cycle.
REQ-017 SHALL support simultaneous push and pop when non-empty and not full, with occupancy unchanged and order preserved; pointers wrap modulo DEPTH.
REQ-018 SHALL implement FSM states IDLE, ROUTE, ACTIVE, with a registered port index PORT.
REQ-019 In IDLE with FIFO non-empty: head HEAD/SINGLE with dest < NR -> latch PORT = dest, go to ROUTE; head BODY/TAIL, or dest >= NR -> pop and discard the head, pulse ERR next cycle, stay in IDLE.
REQ-020 REQ SHALL be one-hot(PORT) in ROUTE, one-hot(PORT) in ACTIVE when FIFO non-empty, else all zero; REQ is combinational from state, PORT and the empty flag only, never from GRT.
REQ-021 In ROUTE, GRT[PORT]=1 -> pop head; next state IDLE if head is SINGLE, else ACTIVE; REQ stays asserted while waiting for a grant, with no timeout.
REQ-022 In ACTIVE, GRT[PORT]=1 with FIFO non-empty -> pop head; popped TAIL -> IDLE; popped HEAD/SINGLE inside a packet -> discard, ERR pulse, stay in ACTIVE.
REQ-023 Grant bits other than GRT[PORT], or any grant in IDLE or with FIFO empty, SHALL be ignored: no pop, no output.
REQ-024 Every forwarded pop SHALL drive OUT_FLIT with the popped flit and OUT_VALID=1 on the cycle after the grant; OUT_FLIT holds its last value otherwise.
REQ-025 Throughput SHALL be one flit per cycle while GRT[PORT] stays asserted and the FIFO is non-empty.
REQ-026 Latency SHALL be: a flit pushed at edge N into an empty FIFO in IDLE gives REQ at cycle N+1, and OUT_VALID the cycle after the first GRT[PORT].

Reset
REQ-027 RST=1 SHALL asynchronously clear the FIFO (empty, pointers 0), state IDLE, PORT=0, REQ=0, OUT_VALID=0, ERR=0, OUT_FLIT=0, IN_READY=1 after release.
REQ-028 Reset mid-packet SHALL discard all buffered flits; the first flit after release must be HEAD/SINGLE or it is dropped with ERR.

Verification
REQ-029 Push SINGLE flit with dest 2, GRT=00100 on the cycle after REQ appears -> REQ=00100 for one cycle, OUT_VALID one cycle later with the same flit, state IDLE.
REQ-030 Push HEAD dest 4, BODY, TAIL; GRT=10000 held -> three consecutive OUT_VALID pulses in order, then REQ=00000.
REQ-031 Fill 4 flits with GRT=0 -> IN_READY=0; then GRT=one-hot(PORT) with IN_VALID=1 held -> no push on the pop cycle, push accepted on the next cycle.
REQ-032 Head flit BODY type, or HEAD with dest 6 -> flit discarded, ERR pulses once, REQ stays 0.
REQ-033 In ROUTE with REQ=00010, apply GRT=00001 for 3 cycles, then 00010 -> no pop until 00010, then OUT_VALID.
REQ-034 Assert RST during ACTIVE with 3 flits buffered -> REQ=0, OUT_VALID=0 immediately; IN_READY=1 and the FIFO is empty after release.

Source files
------------

// File: rtl/input_req_buffer.sv
// Input-port flit buffer for a wormhole router: a small FIFO plus a route/forward FSM
// that requests one output port per packet and forwards flits as that port grants them.
module input_req_buffer #(
    parameter int NR    = 5,
    parameter int FW    = 16,
    parameter int DEPTH = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [FW-1:0] IN_FLIT,
    input  logic          IN_VALID,
    output logic          IN_READY,
    output logic [NR-1:0] REQ,
    input  logic [NR-1:0] GRT,
    output logic [FW-1:0] OUT_FLIT,
    output logic          OUT_VALID,
    output logic          ERR
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROUTE  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    logic [FW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;
    logic [2:0]    port_q, port_d;
    logic [FW-1:0] out_flit_q, out_flit_d;
    logic          out_valid_q, out_valid_d;
    logic          err_q, err_d;

    logic          full_s, empty_s, push_s, pop_s, fwd_s, grant_s;
    logic          head_is_hd_s, dest_ok_s;
    logic [FW-1:0] head_s;
    logic [1:0]    head_type_s;
    logic [2:0]    head_dest_s;
    logic [NR-1:0] port_oh_s;

    // Ready depends only on registered occupancy, so a full FIFO refuses a push even on a pop cycle.
    assign full_s   = (count_q == FULL_CNT);
    assign empty_s  = (count_q == {CW{1'b0}});
    assign IN_READY = !full_s;
    assign push_s   = IN_VALID && !full_s;

    assign head_s       = mem_q[rd_ptr_q];
    assign head_type_s  = head_s[FW-1:FW-2];
    assign head_dest_s  = head_s[FW-3:FW-5];
    assign head_is_hd_s = (head_type_s == T_HEAD) || (head_type_s == T_SINGLE);
    assign dest_ok_s    = ({29'd0, head_dest_s} < 32'(NR));

    assign port_oh_s = {{(NR-1){1'b0}}, 1'b1} << port_q;
    assign grant_s   = |(GRT & port_oh_s);

    assign OUT_FLIT  = out_flit_q;
    assign OUT_VALID = out_valid_q;
    assign ERR       = err_q;

    // Arbiter request: never depends on GRT, so there is no combinational loop through the arbiter.
    always_comb begin
        REQ = {NR{1'b0}};
        if ((state_q == ST_ROUTE) || ((state_q == ST_ACTIVE) && !empty_s)) begin
            REQ = port_oh_s;
        end else begin
            REQ = {NR{1'b0}};
        end
    end

    // Next-state, pop and forward decisions.
    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        pop_s   = 1'b0;
        fwd_s   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_s) begin
                    if (head_is_hd_s && dest_ok_s) begin
                        port_d  = head_dest_s;
                        state_d = ST_ROUTE;
                    end else begin
                        pop_s = 1'b1;
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ROUTE: begin
                if (grant_s && !empty_s) begin
                    pop_s   = 1'b1;
                    fwd_s   = 1'b1;
                    state_d = (head_type_s == T_SINGLE) ? ST_IDLE : ST_ACTIVE;
                end else begin
                    state_d = ST_ROUTE;
                end
            end
            ST_ACTIVE: begin
                if (grant_s && !empty_s) begin
                    pop_s = 1'b1;
                    // A head arriving inside an open packet is corrupt: drop it but keep the packet open.
                    if (head_is_hd_s) begin
                        err_d = 1'b1;
                    end else begin
                        fwd_s = 1'b1;
                    end
                    if (head_type_s == T_TAIL) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ACTIVE;
                    end
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO pointer/occupancy and output register next values.
    always_comb begin
        wr_ptr_d    = push_s ? (wr_ptr_q + {{(AW-1){1'b0}}, 1'b1}) : wr_ptr_q;
        rd_ptr_d    = pop_s  ? (rd_ptr_q + {{(AW-1){1'b0}}, 1'b1}) : rd_ptr_q;
        count_d     = count_q + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
        out_valid_d = fwd_s;
        out_flit_d  = fwd_s ? head_s : out_flit_q;
    end

    // FIFO storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= IN_FLIT;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            count_q     <= {CW{1'b0}};
            state_q     <= ST_IDLE;
            port_q      <= 3'd0;
            out_flit_q  <= {FW{1'b0}};
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            port_q      <= port_d;
            out_flit_q  <= out_flit_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_input_req_buffer.sv
// Directed self-checking bench for input_req_buffer (NR=5, FW=16, DEPTH=4).
module tb_input_req_buffer;

    logic        clk_s = 1'b0;
    logic        rst_s;
    logic [15:0] in_flit_s;
    logic        in_valid_s;
    logic        in_ready_s;
    logic [4:0]  req_s;
    logic [4:0]  grt_s;
    logic [15:0] out_flit_s;
    logic        out_valid_s;
    logic        err_s;

    int checks_r   = 0;
    int failures_r = 0;

    input_req_buffer #(.NR(5), .FW(16), .DEPTH(4)) dut (
        .CLK(clk_s), .RST(rst_s), .IN_FLIT(in_flit_s), .IN_VALID(in_valid_s),
        .IN_READY(in_ready_s), .REQ(req_s), .GRT(grt_s), .OUT_FLIT(out_flit_s),
        .OUT_VALID(out_valid_s), .ERR(err_s)
    );

    // Free-running clock.
    always #5 clk_s = ~clk_s;

    function automatic logic [15:0] mk(input logic [1:0] t, input logic [2:0] d, input logic [10:0] p);
        return {t, d, p};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_r++;
        if (act !== exp) begin
            failures_r++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_s);
        #1;
    endtask

    logic [15:0] f0, f1, f2, f3;

    initial begin
        rst_s = 1'b1; in_flit_s = 16'd0; in_valid_s = 1'b0; grt_s = 5'd0;
        #1;
        check_eq("rst_req", 32'(req_s), 32'd0);
        check_eq("rst_ovalid", 32'(out_valid_s), 32'd0);
        check_eq("rst_err", 32'(err_s), 32'd0);
        check_eq("rst_oflit", 32'(out_flit_s), 32'd0);
        check_eq("rst_ready", 32'(in_ready_s), 32'd1);
        tick; tick;
        rst_s = 1'b0;

        // SINGLE to port 2
        f0 = mk(2'b11, 3'd2, 11'h123);
        in_flit_s = f0; in_valid_s = 1'b1;
        tick;
        in_valid_s = 1'b0;
        check_eq("s_req_idle", 32'(req_s), 32'd0);
        tick;
        check_eq("s_req", 32'(req_s), 32'b00100);
        grt_s = 5'b00100;
        tick;
        grt_s = 5'd0;
        check_eq("s_req_off", 32'(req_s), 32'd0);
        check_eq("s_ovalid", 32'(out_valid_s), 32'd1);
        check_eq("s_oflit", 32'(out_flit_s), 32'(f0));
        tick;
        check_eq("s_ovalid_pulse", 32'(out_valid_s), 32'd0);
        check_eq("s_oflit_hold", 32'(out_flit_s), 32'(f0));
        check_eq("s_req_idle2", 32'(req_s), 32'd0);

        // HEAD/BODY/TAIL to port 4, grant held
        f0 = mk(2'b01, 3'd4, 11'h0A1);
        f1 = mk(2'b00, 3'd0, 11'h0B2);
        f2 = mk(2'b10, 3'd0, 11'h0C3);
        in_valid_s = 1'b1;
        in_flit_s = f0; tick;
        in_flit_s = f1; tick;
        in_flit_s = f2; tick;
        in_valid_s = 1'b0;
        check_eq("p_req", 32'(req_s), 32'b10000);
        grt_s = 5'b10000;
        tick;
        check_eq("p_ov0", 32'(out_valid_s), 32'd1);
        check_eq("p_of0", 32'(out_flit_s), 32'(f0));
        tick;
        check_eq("p_ov1", 32'(out_valid_s), 32'd1);
        check_eq("p_of1", 32'(out_flit_s), 32'(f1));
        tick;
        check_eq("p_ov2", 32'(out_valid_s), 32'd1);
        check_eq("p_of2", 32'(out_flit_s), 32'(f2));
        check_eq("p_req_done", 32'(req_s), 32'd0);
        grt_s = 5'd0;
        tick;
        check_eq("p_ov_end", 32'(out_valid_s), 32'd0);

        // Bad heads: BODY first, then HEAD with dest 6
        for (int k = 0; k < 2; k++) begin
            in_flit_s = (k == 0) ? mk(2'b00, 3'd1, 11'h055) : mk(2'b01, 3'd6, 11'h066);
            in_valid_s = 1'b1;
            tick;
            in_valid_s = 1'b0;
            check_eq("bad_err_pre", 32'(err_s), 32'd0);
            tick;
            check_eq("bad_err", 32'(err_s), 32'd1);
            check_eq("bad_req", 32'(req_s), 32'd0);
            tick;
            check_eq("bad_err_pulse", 32'(err_s), 32'd0);
            check_eq("bad_req2", 32'(req_s), 32'd0);
            check_eq("bad_ready", 32'(in_ready_s), 32'd1);
            check_eq("bad_ovalid", 32'(out_valid_s), 32'd0);
        end

        // Wrong-port grants are ignored
        f0 = mk(2'b01, 3'd1, 11'h111);
        f1 = mk(2'b10, 3'd0, 11'h222);
        in_valid_s = 1'b1;
        in_flit_s = f0; tick;
        in_flit_s = f1; tick;
        in_valid_s = 1'b0;
        check_eq("w_req", 32'(req_s), 32'b00010);
        grt_s = 5'b00001;
        for (int k = 0; k < 3; k++) begin
            tick;
            check_eq("w_no_ov", 32'(out_valid_s), 32'd0);
            check_eq("w_req_hold", 32'(req_s), 32'b00010);
        end
        grt_s = 5'b00010;
        tick;
        check_eq("w_ov0", 32'(out_valid_s), 32'd1);
        check_eq("w_of0", 32'(out_flit_s), 32'(f0));
        tick;
        check_eq("w_ov1", 32'(out_valid_s), 32'd1);
        check_eq("w_of1", 32'(out_flit_s), 32'(f1));
        grt_s = 5'd0;
        tick;
        check_eq("w_req_end", 32'(req_s), 32'd0);
        check_eq("w_ov_end", 32'(out_valid_s), 32'd0);

        // Full FIFO: push refused on the pop cycle, accepted on the next
        f0 = mk(2'b01, 3'd3, 11'h301);
        f1 = mk(2'b00, 3'd0, 11'h302);
        f2 = mk(2'b00, 3'd0, 11'h303);
        f3 = mk(2'b00, 3'd0, 11'h304);
        in_valid_s = 1'b1;
        in_flit_s = f0; tick;
        in_flit_s = f1; tick;
        in_flit_s = f2; tick;
        in_flit_s = f3; tick;
        check_eq("f_ready_full", 32'(in_ready_s), 32'd0);
        check_eq("f_req", 32'(req_s), 32'b01000);
        in_flit_s = mk(2'b10, 3'd0, 11'h305);
        grt_s = 5'b01000;
        tick;
        check_eq("f_of0", 32'(out_flit_s), 32'(f0));
        check_eq("f_ready_after", 32'(in_ready_s), 32'd1);
        tick;
        in_valid_s = 1'b0;
        check_eq("f_of1", 32'(out_flit_s), 32'(f1));
        tick;
        check_eq("f_of2", 32'(out_flit_s), 32'(f2));
        tick;
        check_eq("f_of3", 32'(out_flit_s), 32'(f3));
        tick;
        check_eq("f_ov4", 32'(out_valid_s), 32'd1);
        check_eq("f_of4", 32'(out_flit_s), 32'(mk(2'b10, 3'd0, 11'h305)));
        check_eq("f_req_end", 32'(req_s), 32'd0);
        grt_s = 5'd0;
        tick;
        check_eq("f_err_end", 32'(err_s), 32'd0);
        check_eq("f_ov_end", 32'(out_valid_s), 32'd0);
        check_eq("f_ready_end", 32'(in_ready_s), 32'd1);

        // Reset during ACTIVE with 3 flits buffered
        in_valid_s = 1'b1;
        in_flit_s = mk(2'b01, 3'd0, 11'h401); tick;
        in_flit_s = mk(2'b00, 3'd0, 11'h402); tick;
        in_flit_s = mk(2'b00, 3'd0, 11'h403); tick;
        in_flit_s = mk(2'b00, 3'd0, 11'h404); tick;
        in_valid_s = 1'b0;
        grt_s = 5'b00001;
        tick;
        grt_s = 5'd0;
        check_eq("r_ov_pre", 32'(out_valid_s), 32'd1);
        check_eq("r_req_active", 32'(req_s), 32'b00001);
        #2;
        rst_s = 1'b1;
        #1;
        check_eq("r_req_async", 32'(req_s), 32'd0);
        check_eq("r_ov_async", 32'(out_valid_s), 32'd0);
        check_eq("r_of_async", 32'(out_flit_s), 32'd0);
        tick;
        rst_s = 1'b0;
        tick;
        check_eq("r_ready", 32'(in_ready_s), 32'd1);
        check_eq("r_req_empty", 32'(req_s), 32'd0);
        check_eq("r_ov_empty", 32'(out_valid_s), 32'd0);
        in_flit_s = mk(2'b00, 3'd0, 11'h405);
        in_valid_s = 1'b1;
        tick;
        in_valid_s = 1'b0;
        tick;
        check_eq("r_body_err", 32'(err_s), 32'd1);
        check_eq("r_body_req", 32'(req_s), 32'd0);
        tick;
        check_eq("r_err_pulse", 32'(err_s), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
